// File: rtl/tdp18k_preload_ctl.sv
// tdp18k_preload_ctl
// Preload sequencer for the TDP18K_FIFO preload port (1024 x 18).
// It takes a load command and a stream of 18-bit words, writes the words
// through the PL_* port, and in verify mode reads the range back and compares
// a rotate-xor checksum of the readback against the write-side checksum.
module tdp18k_preload_ctl (
   input  logic        CLK_i,
   input  logic        RST_i,
   input  logic        CMD_VALID_i,
   output logic        CMD_READY_o,
   input  logic [19:0] CMD_RAM_ID_i,
   input  logic        CMD_BCAST_i,
   input  logic [9:0]  CMD_BASE_i,
   input  logic [10:0] CMD_LEN_i,
   input  logic        CMD_VERIFY_i,
   input  logic        DIN_VALID_i,
   output logic        DIN_READY_o,
   input  logic [17:0] DIN_DATA_i,
   output logic        PL_INIT_o,
   output logic        PL_ENA_o,
   output logic        PL_WEN_o,
   output logic        PL_REN_o,
   output logic [31:0] PL_ADDR_o,
   output logic [17:0] PL_DATA_IN_o,
   input  logic [17:0] PL_DATA_OUT_i,
   output logic        BUSY_o,
   output logic        DONE_o,
   output logic        ERR_o,
   output logic [17:0] CSUM_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_CHECK = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   // Order-sensitive checksum step: rotate left by one, then fold in the word.
   function automatic logic [17:0] csum_step(input logic [17:0] c, input logic [17:0] w);
      csum_step = {c[16:0], c[17]} ^ w;
   endfunction

   state_t      r_state;
   state_t      w_next;

   // Latched command fields
   logic [19:0] r_ram_id;
   logic        r_bcast;
   logic        r_vfy;
   logic [9:0]  r_base;
   logic [10:0] r_len;

   // Word address and remaining-word counter, shared by write and read phases
   logic [9:0]  r_addr;
   logic [10:0] r_cnt;

   // Registered outputs
   logic        r_init;
   logic        r_ena;
   logic        r_wen;
   logic        r_ren;
   logic        r_ren_d1;
   logic [31:0] r_pl_addr;
   logic [17:0] r_pl_din;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [17:0] r_csum;
   logic [17:0] r_rcsum;

   // Decoded handshake and helper signals
   logic        w_cmd_ready;
   logic        w_din_ready;
   logic        w_cmd_hs;
   logic        w_din_hs;
   logic        w_last_wr;
   logic        w_rd_issue;
   logic        w_ena_nxt;
   logic        w_bcast_nxt;
   logic [17:0] w_rcsum_nxt;

   assign w_cmd_ready = (r_state == S_IDLE);
   assign w_din_ready = (r_state == S_WRITE) && (r_cnt != 11'd0);
   assign w_cmd_hs    = w_cmd_ready && CMD_VALID_i;
   assign w_din_hs    = w_din_ready && DIN_VALID_i;
   assign w_last_wr   = w_din_hs && (r_cnt == 11'd1);
   assign w_rd_issue  = (r_state == S_READ);
   assign w_bcast_nxt = w_cmd_hs ? CMD_BCAST_i : r_bcast;

   // The final read word is captured on the same edge that leaves CHECK,
   // so the comparison uses the checksum including that capture.
   assign w_rcsum_nxt = r_ren_d1 ? csum_step(r_rcsum, PL_DATA_OUT_i) : r_rcsum;

   // State register
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_next    = r_state;
      w_ena_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_hs) begin
               w_next = (CMD_LEN_i == 11'd0) ? S_FIN : S_WRITE;
            end
         end
         S_WRITE: begin
            if (w_last_wr) begin
               w_next = r_vfy ? S_READ : S_DRAIN;
            end
         end
         S_READ: begin
            if (r_cnt <= 11'd1) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_next = r_vfy ? S_CHECK : S_FIN;
         end
         S_CHECK: begin
            w_next = S_FIN;
         end
         S_FIN: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
      w_ena_nxt = (w_next == S_WRITE) || (w_next == S_READ) ||
                  (w_next == S_DRAIN) || (w_next == S_CHECK);
   end

   // Command latch plus address and word counters
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         r_ram_id <= 20'd0;
         r_bcast  <= 1'b0;
         r_vfy    <= 1'b0;
         r_base   <= 10'd0;
         r_len    <= 11'd0;
         r_addr   <= 10'd0;
         r_cnt    <= 11'd0;
      end else if (w_cmd_hs) begin
         r_ram_id <= CMD_RAM_ID_i;
         r_bcast  <= CMD_BCAST_i;
         // Readback from several RAMs at once is undefined, so broadcast drops verify
         r_vfy    <= CMD_VERIFY_i & ~CMD_BCAST_i;
         r_base   <= CMD_BASE_i;
         r_len    <= CMD_LEN_i;
         r_addr   <= CMD_BASE_i;
         r_cnt    <= CMD_LEN_i;
      end else if (w_last_wr) begin
         // Rewind for the readback pass
         r_addr   <= r_base;
         r_cnt    <= r_len;
      end else if (w_din_hs || w_rd_issue) begin
         r_addr   <= r_addr + 10'd1;
         r_cnt    <= r_cnt - 11'd1;
      end
   end

   // Preload port strobes, address and write data
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         r_ena     <= 1'b0;
         r_init    <= 1'b0;
         r_wen     <= 1'b0;
         r_ren     <= 1'b0;
         r_ren_d1  <= 1'b0;
         r_pl_addr <= 32'd0;
         r_pl_din  <= 18'd0;
      end else begin
         r_ena    <= w_ena_nxt;
         r_init   <= w_ena_nxt & w_bcast_nxt;
         r_wen    <= w_din_hs;
         r_ren    <= w_rd_issue;
         r_ren_d1 <= r_ren;
         if (w_din_hs) begin
            r_pl_addr <= {r_ram_id, 2'b00, r_addr};
            r_pl_din  <= DIN_DATA_i;
         end else if (w_rd_issue) begin
            r_pl_addr <= {r_ram_id, 2'b00, r_addr};
         end
      end
   end

   // Checksums, error flag and status
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         r_csum  <= 18'd0;
         r_rcsum <= 18'd0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_busy <= (w_next != S_IDLE);
         r_done <= (r_state == S_FIN);
         if (w_cmd_hs) begin
            r_csum  <= 18'd0;
            r_rcsum <= 18'd0;
            r_err   <= 1'b0;
         end else begin
            if (w_din_hs) begin
               r_csum <= csum_step(r_csum, DIN_DATA_i);
            end
            r_rcsum <= w_rcsum_nxt;
            if ((r_state == S_CHECK) && (w_rcsum_nxt != r_csum)) begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign CMD_READY_o  = w_cmd_ready;
   assign DIN_READY_o  = w_din_ready;
   assign PL_INIT_o    = r_init;
   assign PL_ENA_o     = r_ena;
   assign PL_WEN_o     = r_wen;
   assign PL_REN_o     = r_ren;
   assign PL_ADDR_o    = r_pl_addr;
   assign PL_DATA_IN_o = r_pl_din;
   assign BUSY_o       = r_busy;
   assign DONE_o       = r_done;
   assign ERR_o        = r_err;
   assign CSUM_o       = r_csum;

endmodule

// File: tb/tb_tdp18k_preload_ctl.sv
// Directed testbench for tdp18k_preload_ctl with a small preload RAM model.
module tb_tdp18k_preload_ctl;

   logic        CLK_i = 1'b0;
   logic        RST_i;
   logic        CMD_VALID_i;
   logic        CMD_READY_o;
   logic [19:0] CMD_RAM_ID_i;
   logic        CMD_BCAST_i;
   logic [9:0]  CMD_BASE_i;
   logic [10:0] CMD_LEN_i;
   logic        CMD_VERIFY_i;
   logic        DIN_VALID_i;
   logic        DIN_READY_o;
   logic [17:0] DIN_DATA_i;
   logic        PL_INIT_o;
   logic        PL_ENA_o;
   logic        PL_WEN_o;
   logic        PL_REN_o;
   logic [31:0] PL_ADDR_o;
   logic [17:0] PL_DATA_IN_o;
   logic [17:0] PL_DATA_OUT_i = 18'd0;
   logic        BUSY_o;
   logic        DONE_o;
   logic        ERR_o;
   logic [17:0] CSUM_o;

   tdp18k_preload_ctl dut (
      .CLK_i(CLK_i), .RST_i(RST_i),
      .CMD_VALID_i(CMD_VALID_i), .CMD_READY_o(CMD_READY_o),
      .CMD_RAM_ID_i(CMD_RAM_ID_i), .CMD_BCAST_i(CMD_BCAST_i),
      .CMD_BASE_i(CMD_BASE_i), .CMD_LEN_i(CMD_LEN_i), .CMD_VERIFY_i(CMD_VERIFY_i),
      .DIN_VALID_i(DIN_VALID_i), .DIN_READY_o(DIN_READY_o), .DIN_DATA_i(DIN_DATA_i),
      .PL_INIT_o(PL_INIT_o), .PL_ENA_o(PL_ENA_o), .PL_WEN_o(PL_WEN_o), .PL_REN_o(PL_REN_o),
      .PL_ADDR_o(PL_ADDR_o), .PL_DATA_IN_o(PL_DATA_IN_o), .PL_DATA_OUT_i(PL_DATA_OUT_i),
      .BUSY_o(BUSY_o), .DONE_o(DONE_o), .ERR_o(ERR_o), .CSUM_o(CSUM_o)
   );

   always #5 CLK_i = ~CLK_i;

   int cyc = 0;
   always @(posedge CLK_i) cyc <= cyc + 1;

   // Preload RAM model: write sampled at the edge after PL_WEN_o,
   // read data valid one edge after PL_REN_o; optional single-address corruption.
   logic [17:0] mem [0:1023];
   logic        corrupt = 1'b0;
   logic [9:0]  corrupt_addr = 10'd0;
   always @(posedge CLK_i) begin
      if (PL_WEN_o) mem[PL_ADDR_o[9:0]] <= PL_DATA_IN_o;
      if (PL_REN_o)
         PL_DATA_OUT_i <= mem[PL_ADDR_o[9:0]] ^
                          ((corrupt && (PL_ADDR_o[9:0] == corrupt_addr)) ? 18'd1 : 18'd0);
   end

   // Activity monitor sampled on the falling edge
   int          wn = 0, rn = 0, dn = 0, both = 0, initw = 0, ena_n = 0, busyrdy = 0, done_cyc = 0;
   logic [31:0] wa [0:255];
   logic [17:0] wd [0:255];
   logic [31:0] ra [0:255];
   always @(negedge CLK_i) begin
      if (PL_WEN_o) begin
         wa[wn[7:0]] <= PL_ADDR_o;
         wd[wn[7:0]] <= PL_DATA_IN_o;
         wn <= wn + 1;
      end
      if (PL_REN_o) begin
         ra[rn[7:0]] <= PL_ADDR_o;
         rn <= rn + 1;
      end
      if (PL_WEN_o && PL_REN_o) both <= both + 1;
      if (PL_WEN_o && PL_INIT_o) initw <= initw + 1;
      if (PL_ENA_o) ena_n <= ena_n + 1;
      if (BUSY_o && CMD_READY_o) busyrdy <= busyrdy + 1;
      if (DONE_o) begin
         dn <= dn + 1;
         done_cyc <= cyc;
      end
   end

   int          n_tests = 0;
   int          n_fail = 0;
   int          hs;
   int          wn0, rn0, dn0, initw0, ena0, busyrdy0;
   logic [17:0] wq [0:7];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      wn0 = wn; rn0 = rn; dn0 = dn; initw0 = initw; ena0 = ena_n; busyrdy0 = busyrdy;
   endtask

   task automatic start_cmd(input logic [19:0] id, input logic bc, input logic [9:0] base,
                            input logic [10:0] len, input logic vf);
      int g;
      g = 0;
      while (!CMD_READY_o && g < 100) begin
         @(posedge CLK_i); #1; g++;
      end
      CMD_RAM_ID_i = id; CMD_BCAST_i = bc; CMD_BASE_i = base;
      CMD_LEN_i = len; CMD_VERIFY_i = vf; CMD_VALID_i = 1'b1;
      @(posedge CLK_i); #1;
      hs = cyc;
      CMD_VALID_i = 1'b0;
   endtask

   task automatic send_words(input int n, input bit gap);
      int  idx;
      int  g;
      bit  acc;
      idx = 0; g = 0;
      while (idx < n && g < 200) begin
         DIN_VALID_i = gap ? ~g[0] : 1'b1;
         DIN_DATA_i  = wq[idx[2:0]];
         acc = DIN_VALID_i && DIN_READY_o;
         @(posedge CLK_i); #1;
         if (acc) idx++;
         g++;
      end
      DIN_VALID_i = 1'b0;
      chk("words_accepted", idx, n);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK_i); #1;
         if (dn != dn0) break;
      end
      chk(tag, dn - dn0, 1);
   endtask

   initial begin
      RST_i = 1'b1;
      CMD_VALID_i = 1'b0; CMD_RAM_ID_i = '0; CMD_BCAST_i = 1'b0; CMD_BASE_i = '0;
      CMD_LEN_i = '0; CMD_VERIFY_i = 1'b0; DIN_VALID_i = 1'b0; DIN_DATA_i = '0;
      repeat (3) @(posedge CLK_i);
      #1 RST_i = 1'b0;
      @(posedge CLK_i); #1;

      // Reset state
      chk("rst_cmd_ready", CMD_READY_o, 1);
      chk("rst_busy", BUSY_o, 0);
      chk("rst_done", DONE_o, 0);
      chk("rst_ena", PL_ENA_o, 0);
      chk("rst_wen", PL_WEN_o, 0);
      chk("rst_ren", PL_REN_o, 0);
      chk("rst_err", ERR_o, 0);
      chk("rst_csum", CSUM_o, 0);
      chk("rst_addr", PL_ADDR_o, 0);
      chk("rst_din_ready", DIN_READY_o, 0);

      // Plain load
      wq[0] = 18'd1; wq[1] = 18'd2; wq[2] = 18'd3; wq[3] = 18'd4;
      snap();
      start_cmd(20'h00401, 1'b0, 10'd0, 11'd4, 1'b0);
      chk("plain_busy", BUSY_o, 1);
      chk("plain_cmd_ready", CMD_READY_o, 0);
      send_words(4, 1'b0);
      wait_done("plain_done");
      chk("plain_latency", done_cyc + 1 - hs, 7);
      chk("plain_wen_count", wn - wn0, 4);
      for (int i = 0; i < 4; i++) begin
         chk("plain_addr", wa[wn0 + i], 32'h00401000 + i);
         chk("plain_data", wd[wn0 + i], wq[i]);
      end
      chk("plain_csum", CSUM_o, 18'h00002);
      chk("plain_ren_count", rn - rn0, 0);
      chk("plain_init", initw - initw0, 0);
      chk("plain_err", ERR_o, 0);

      // Verify pass
      snap();
      start_cmd(20'h00401, 1'b0, 10'd0, 11'd4, 1'b1);
      send_words(4, 1'b0);
      wait_done("vpass_done");
      chk("vpass_latency", done_cyc + 1 - hs, 12);
      chk("vpass_ren_count", rn - rn0, 4);
      for (int i = 0; i < 4; i++) chk("vpass_raddr", ra[rn0 + i], 32'h00401000 + i);
      chk("vpass_err", ERR_o, 0);
      chk("vpass_csum", CSUM_o, 18'h00002);

      // Verify fail: word 2 read back with bit 0 flipped
      corrupt = 1'b1; corrupt_addr = 10'd2;
      snap();
      start_cmd(20'h00401, 1'b0, 10'd0, 11'd4, 1'b1);
      send_words(4, 1'b0);
      wait_done("vfail_done");
      chk("vfail_latency", done_cyc + 1 - hs, 12);
      chk("vfail_err", ERR_o, 1);
      repeat (3) @(posedge CLK_i);
      #1 chk("vfail_err_held", ERR_o, 1);
      corrupt = 1'b0;

      // Wrap and stalls
      wq[0] = 18'h20001; wq[1] = 18'h00002; wq[2] = 18'h00004; wq[3] = 18'h00008;
      snap();
      start_cmd(20'h00055, 1'b0, 10'd1022, 11'd4, 1'b0);
      chk("wrap_err_cleared", ERR_o, 0);
      send_words(4, 1'b1);
      wait_done("wrap_done");
      chk("wrap_wen_count", wn - wn0, 4);
      chk("wrap_addr0", wa[wn0 + 0], 32'h000553FE);
      chk("wrap_addr1", wa[wn0 + 1], 32'h000553FF);
      chk("wrap_addr2", wa[wn0 + 2], 32'h00055000);
      chk("wrap_addr3", wa[wn0 + 3], 32'h00055001);
      for (int i = 0; i < 4; i++) chk("wrap_data", wd[wn0 + i], wq[i]);
      chk("wrap_csum", CSUM_o, 18'h00004);
      chk("wrap_cmd_ready_busy", busyrdy - busyrdy0, 0);

      // LEN = 0
      snap();
      start_cmd(20'h00001, 1'b0, 10'd5, 11'd0, 1'b0);
      wait_done("len0_done");
      chk("len0_latency", done_cyc + 1 - hs, 2);
      chk("len0_wen", wn - wn0, 0);
      chk("len0_ren", rn - rn0, 0);
      chk("len0_ena", ena_n - ena0, 0);
      chk("len0_csum", CSUM_o, 0);

      // Broadcast with verify
      wq[0] = 18'd5; wq[1] = 18'd6;
      snap();
      start_cmd(20'h00002, 1'b1, 10'd100, 11'd2, 1'b1);
      send_words(2, 1'b0);
      wait_done("bcast_done");
      chk("bcast_latency", done_cyc + 1 - hs, 5);
      chk("bcast_init_writes", initw - initw0, 2);
      chk("bcast_ren", rn - rn0, 0);
      chk("bcast_err", ERR_o, 0);
      chk("bcast_csum", CSUM_o, 18'd12);

      // Reset mid-write
      for (int i = 0; i < 8; i++) wq[i] = 18'h100 + i;
      snap();
      start_cmd(20'h00003, 1'b0, 10'd16, 11'd8, 1'b0);
      send_words(2, 1'b0);
      chk("mid_wen_before_rst", PL_WEN_o, 1);
      #1 RST_i = 1'b1;
      #1;
      chk("mid_rst_ena", PL_ENA_o, 0);
      chk("mid_rst_wen", PL_WEN_o, 0);
      chk("mid_rst_busy", BUSY_o, 0);
      chk("mid_rst_cmd_ready", CMD_READY_o, 1);
      @(posedge CLK_i); #1 RST_i = 1'b0;
      repeat (12) @(negedge CLK_i);
      #1 chk("mid_rst_no_done", dn - dn0, 0);

      // New command after reset
      wq[0] = 18'h00015; wq[1] = 18'h00001;
      snap();
      start_cmd(20'h00004, 1'b0, 10'd32, 11'd2, 1'b0);
      send_words(2, 1'b0);
      wait_done("post_rst_done");
      chk("post_rst_latency", done_cyc + 1 - hs, 5);
      chk("post_rst_wen", wn - wn0, 2);
      chk("post_rst_addr0", wa[wn0 + 0], 32'h00004020);
      chk("post_rst_addr1", wa[wn0 + 1], 32'h00004021);
      chk("post_rst_csum", CSUM_o, 18'h0002B);

      chk("wen_ren_overlap", both, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tdp18k_preload_ctl.md
# tdp18k_preload_ctl

Preload sequencer that sits directly upstream of the TDP18K_FIFO preload port and drives its PL_* inputs. It accepts a load command (target RAM ID, base word address, length, verify flag) and a stream of 18-bit data words. It writes the words into the addressed RAM through the preload path. In verify mode it reads the same range back through PL_DATA_OUT and compares a running checksum against the one accumulated during the write.

## Interface

Parameters:
- None; widths are fixed to the TDP18K preload port (1024 x 18).

Ports:
- CLK_i  in  1  preload clock; drives the TDP18K PL_CLK_i
- RST_i  in  1  asynchronous, active-high reset
- CMD_VALID_i  in  1  command valid
- CMD_READY_o  out  1  command accepted when high with CMD_VALID_i
- CMD_RAM_ID_i  in  20  target RAM ID; sub-field value 0 is a wildcard at the RAM
- CMD_BCAST_i  in  1  broadcast; drives PL_INIT_o for the command
- CMD_BASE_i  in  10  first word address
- CMD_LEN_i  in  11  word count, 0..1024
- CMD_VERIFY_i  in  1  read back and check after the write
- DIN_VALID_i  in  1  data word valid
- DIN_READY_o  out  1  data word accepted when high with DIN_VALID_i
- DIN_DATA_i  in  18  data word
- PL_INIT_o  out  1  to TDP18K PL_INIT_i
- PL_ENA_o  out  1  to TDP18K PL_ENA_i
- PL_WEN_o  out  1  to TDP18K PL_WEN_i
- PL_REN_o  out  1  to TDP18K PL_REN_i
- PL_ADDR_o  out  32  to TDP18K PL_ADDR_i, as {RAM_ID[19:0], 2'b00, word_addr[9:0]}
- PL_DATA_IN_o  out  18  to TDP18K PL_DATA_IN_i
- PL_DATA_OUT_i  in  18  from TDP18K PL_DATA_OUT_o
- BUSY_o  out  1  high in every state except IDLE
- DONE_o  out  1  one-cycle pulse at command completion
- ERR_o  out  1  verify mismatch; held until the next command is accepted
- CSUM_o  out  18  write-side checksum of the last command

## Operation

- **Reset values:** all outputs 0 except CMD_READY_o = 1. State is IDLE. Checksums and counters are 0.
- **States:**
  - IDLE: CMD_READY_o = 1. A command handshake latches the command fields, clears ERR_o, CSUM_o and the read checksum, and moves to WRITE. If CMD_LEN_i = 0, it moves to FIN instead.
  - WRITE: DIN_READY_o = 1 while words remain. Each data handshake registers one preload write and advances the address. The last handshake moves to READ if verify is set and broadcast is clear; otherwise it moves to DRAIN.
  - READ: issues one PL_REN_o per cycle for LEN consecutive cycles starting at BASE. Data is captured 1 cycle after each read. After the last read is issued, moves to DRAIN.
  - DRAIN: one cycle, so the last write completes or the last read data is captured. Then moves to CHECK if verify was active, else to FIN.
  - CHECK: one cycle. Sets ERR_o = 1 if the read checksum differs from CSUM_o. Moves to FIN.
  - FIN: DONE_o = 1 for one cycle. Returns to IDLE.
- **Address:** word_addr = (BASE + i) mod 1024. The 10-bit counter wraps naturally; BASE = 1020 with LEN = 8 writes addresses 1020..1023, then 0..3.
- **Checksum:** csum <= {csum[16:0], csum[17]} ^ word, over 18 bits.
  - The write side updates on each data handshake.
  - The read side updates on each captured PL_DATA_OUT_i.
  - The checksum is order-sensitive.
- **PL_ENA_o:** 1 in WRITE, READ, DRAIN and CHECK; 0 in IDLE and FIN.
- **PL_INIT_o:** equals the latched CMD_BCAST_i whenever PL_ENA_o is 1; otherwise 0.
- **Broadcast with verify:** verify is skipped and ERR_o stays 0, because readback from multiple RAMs is undefined.
- **PL_WEN_o and PL_REN_o:** never high in the same cycle.
- **Data and address outputs:** PL_DATA_IN_o holds the last written word. PL_ADDR_o holds the last issued address.
- **Commands while busy:** not accepted (CMD_READY_o = 0). DIN_READY_o = 0 outside WRITE.

## Timing

- All outputs are registered, except that CMD_READY_o and DIN_READY_o are decoded from the state register.
- Command handshake at edge N: WRITE is entered and BUSY_o = 1 after edge N.
- Data handshake at edge k: after edge k, PL_WEN_o = 1 with its address and data, held for exactly 1 cycle. The RAM samples the write at edge k+1.
- Back-to-back data: one write per cycle. A DIN_VALID_i gap deasserts PL_WEN_o for the gap.
- Read issued after edge r (PL_REN_o = 1): PL_DATA_OUT_i is valid after edge r+1 and is captured at edge r+2.
- Total latency for LEN = L with no data stalls, counted from the command handshake:
  - no verify: L+3 cycles to DONE_o;
  - verify: 2L+4 cycles to DONE_o.
- LEN = 0: DONE_o is asserted 2 cycles after the handshake, with no PL_WEN_o or PL_REN_o.
- RST_i asserted mid-command: all outputs are cleared immediately (asynchronously), including PL_ENA_o and PL_WEN_o. No DONE_o is produced. The partially written range is left as-is.

## Test plan

- **Plain load:** ID = 0x00401, BASE = 0, LEN = 4, words 1, 2, 3, 4 back-to-back.
  - Required: four PL_WEN_o pulses, PL_ADDR_o = 0x00401000..0x00401003, PL_DATA_IN_o matching each word.
  - Required: DONE_o at handshake + 7. CSUM_o equals the reference checksum.
- **Verify pass:** same load with CMD_VERIFY_i = 1 and a RAM model returning the written data.
  - Required: four PL_REN_o pulses after the writes, ERR_o = 0, DONE_o at handshake + 12.
- **Verify fail:** the RAM model corrupts word 2 (bit 0 flipped).
  - Required: ERR_o = 1 from the CHECK cycle until the next command.
- **Wrap and stalls:** BASE = 1022, LEN = 4, with DIN_VALID_i low on alternate cycles.
  - Required: addresses 1022, 1023, 0, 1; PL_WEN_o only after accepted words.
  - Required: CMD_READY_o = 0 throughout the command.
- **Edge commands:**
  - LEN = 0: DONE_o after 2 cycles, no PL activity.
  - Broadcast with verify: PL_INIT_o = 1 during the writes, no PL_REN_o, ERR_o = 0.
- **Reset mid-write:** assert RST_i after the 2nd of 8 words.
  - Required: PL_ENA_o, PL_WEN_o and BUSY_o go to 0 asynchronously, CMD_READY_o = 1, no DONE_o.
  - Required: a new command is accepted normally afterwards.
